// File: rtl/gemm_accelerator_if.sv
// SRAM-side bus of the GEMM engine: A/B read ports and the C write port.
// The master modport is the accelerator; the slave modport is the memory side.
interface gemm_accelerator_if #(
  parameter int InDataWidth  = 8,
  parameter int OutDataWidth = 32,
  parameter int AddrWidth    = 12
);
  logic [AddrWidth-1:0]    sram_a_addr;
  logic [AddrWidth-1:0]    sram_b_addr;
  logic [InDataWidth-1:0]  sram_a_rdata;
  logic [InDataWidth-1:0]  sram_b_rdata;
  logic [AddrWidth-1:0]    sram_c_addr;
  logic [OutDataWidth-1:0] sram_c_wdata;
  logic                    sram_c_we;

  modport master (
    output sram_a_addr, sram_b_addr, sram_c_addr, sram_c_wdata, sram_c_we,
    input  sram_a_rdata, sram_b_rdata
  );

  modport slave (
    input  sram_a_addr, sram_b_addr, sram_c_addr, sram_c_wdata, sram_c_we,
    output sram_a_rdata, sram_b_rdata
  );
endinterface

// File: rtl/gemm_accelerator.sv
// Single-MAC signed GEMM engine: C = A x B, row-major, m/n/k loop order,
// streaming one product per cycle from synchronous-read SRAMs.
module gemm_accelerator #(
  parameter int InDataWidth   = 8,
  parameter int OutDataWidth  = 32,
  parameter int AddrWidth     = 12,
  parameter int SizeAddrWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic                     done_o,
  gemm_accelerator_if.master       sram
);

  typedef enum logic [2:0] {Idle, Run, Last, Write, Done} state_e;

  state_e                   state_q, state_d;
  logic [SizeAddrWidth-1:0] mSize_q, mSize_d, kSize_q, kSize_d, nSize_q, nSize_d;
  logic [SizeAddrWidth-1:0] m_q, m_d, n_q, n_d, k_q, k_d;
  logic [AddrWidth-1:0]     aBase_q, aBase_d, aAddr_q, aAddr_d;
  logic [AddrWidth-1:0]     bAddr_q, bAddr_d, cAddr_q, cAddr_d;
  logic [OutDataWidth-1:0]  acc_q, acc_d;

  logic signed [2*InDataWidth-1:0] product;
  logic [OutDataWidth-1:0]         productExt;

  // Read data arriving this cycle belongs to the address issued last cycle.
  assign product    = $signed(sram.sram_a_rdata) * $signed(sram.sram_b_rdata);
  assign productExt = {{(OutDataWidth-2*InDataWidth){product[2*InDataWidth-1]}}, product};

  always_comb begin
    state_d = state_q;
    mSize_d = mSize_q;
    kSize_d = kSize_q;
    nSize_d = nSize_q;
    m_d     = m_q;
    n_d     = n_q;
    k_d     = k_q;
    aBase_d = aBase_q;
    aAddr_d = aAddr_q;
    bAddr_d = bAddr_q;
    cAddr_d = cAddr_q;
    acc_d   = acc_q;
    unique case (state_q)
      Idle: begin
        if (start_i) begin
          mSize_d = M_size_i;
          kSize_d = K_size_i;
          nSize_d = N_size_i;
          m_d     = '0;
          n_d     = '0;
          k_d     = '0;
          aBase_d = '0;
          aAddr_d = '0;
          bAddr_d = '0;
          cAddr_d = '0;
          acc_d   = '0;
          if (M_size_i == '0 || K_size_i == '0 || N_size_i == '0) state_d = Done;
          else                                                    state_d = Run;
        end
      end
      Run: begin
        // k = 0 has no product in flight yet; the accumulator was just cleared.
        if (k_q != '0) acc_d = acc_q + productExt;
        if (k_q == kSize_q - 1'b1) begin
          state_d = Last;
        end else begin
          k_d     = k_q + 1'b1;
          aAddr_d = aAddr_q + 1'b1;
          bAddr_d = bAddr_q + AddrWidth'(nSize_q);
        end
      end
      Last: begin
        acc_d   = acc_q + productExt;
        state_d = Write;
      end
      Write: begin
        acc_d   = '0;
        k_d     = '0;
        cAddr_d = cAddr_q + 1'b1;
        if (n_q == nSize_q - 1'b1) begin
          n_d = '0;
          if (m_q == mSize_q - 1'b1) begin
            state_d = Done;
          end else begin
            m_d     = m_q + 1'b1;
            aBase_d = aBase_q + AddrWidth'(kSize_q);
            aAddr_d = aBase_q + AddrWidth'(kSize_q);
            bAddr_d = '0;
            state_d = Run;
          end
        end else begin
          n_d     = n_q + 1'b1;
          aAddr_d = aBase_q;
          bAddr_d = AddrWidth'(n_q) + 1'b1;
          state_d = Run;
        end
      end
      Done: state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Idle;
      mSize_q <= '0;
      kSize_q <= '0;
      nSize_q <= '0;
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      aBase_q <= '0;
      aAddr_q <= '0;
      bAddr_q <= '0;
      cAddr_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      mSize_q <= mSize_d;
      kSize_q <= kSize_d;
      nSize_q <= nSize_d;
      m_q     <= m_d;
      n_q     <= n_d;
      k_q     <= k_d;
      aBase_q <= aBase_d;
      aAddr_q <= aAddr_d;
      bAddr_q <= bAddr_d;
      cAddr_q <= cAddr_d;
      acc_q   <= acc_d;
    end
  end

  assign sram.sram_a_addr  = aAddr_q;
  assign sram.sram_b_addr  = bAddr_q;
  assign sram.sram_c_addr  = cAddr_q;
  assign sram.sram_c_wdata = acc_q;
  assign sram.sram_c_we    = (state_q == Write);
  assign done_o            = (state_q == Done);

endmodule

// File: tb/tb_gemm_accelerator.sv
// Directed and random self-checking bench for gemm_accelerator with
// behavioural synchronous-read A/B memories and a C write monitor.
module tb_gemm_accelerator;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] mSize, kSize, nSize;
  logic       doneO;

  gemm_accelerator_if #(.InDataWidth(8), .OutDataWidth(32), .AddrWidth(12)) bus ();

  gemm_accelerator #(
    .InDataWidth(8), .OutDataWidth(32), .AddrWidth(12), .SizeAddrWidth(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .M_size_i(mSize), .K_size_i(kSize), .N_size_i(nSize),
    .done_o(doneO), .sram(bus.master)
  );

  logic [7:0]  memA [4096];
  logic [7:0]  memB [4096];
  logic [31:0] memC [4096];

  int checkCount = 0;
  int passCount  = 0;
  int edgeCnt    = 0;
  int acceptEdge = 0;
  int weCount    = 0;
  int orderErr   = 0;
  int doneCount  = 0;
  int doneCycle  = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories: data for the address seen at an edge appears after it.
  always @(posedge clk) begin
    edgeCnt++;
    bus.sram_a_rdata <= memA[bus.sram_a_addr];
    bus.sram_b_rdata <= memB[bus.sram_b_addr];
  end

  always @(negedge clk) begin
    if (bus.sram_c_we) begin
      if (bus.sram_c_addr != 12'(weCount)) orderErr++;
      memC[bus.sram_c_addr] = bus.sram_c_wdata;
      weCount++;
    end
    if (doneO) begin
      doneCount++;
      doneCycle = edgeCnt + 1 - acceptEdge;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, $signed(obs), $signed(exp));
  endtask

  task automatic applyStimulus(input int m, input int k, input int n);
    @(negedge clk);
    mSize = 8'(m);
    kSize = 8'(k);
    nSize = 8'(n);
    weCount   = 0;
    orderErr  = 0;
    doneCount = 0;
    doneCycle = -1;
    for (int i = 0; i < 4096; i++) memC[i] = 32'hDEAD_BEEF;
    start = 1'b1;
    @(posedge clk);
    #1;
    acceptEdge = edgeCnt;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    for (int i = 0; i < budget && doneCount == 0; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput({tag, "_done_seen"}, 32'(doneCount > 0), 32'd1);
    repeat (4) @(negedge clk);
    #1;
  endtask

  function automatic int goldenErrors(input int m, input int k, input int n);
    int errs = 0;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++) begin
        int e = 0;
        for (int p = 0; p < k; p++)
          e += int'($signed(memA[i*k+p])) * int'($signed(memB[p*n+j]));
        if (memC[i*n+j] !== 32'(e)) errs++;
      end
    return errs;
  endfunction

  task automatic load2x2();
    memA[0] = 8'd1; memA[1] = 8'd2; memA[2] = 8'd3; memA[3] = 8'd4;
    memB[0] = 8'd5; memB[1] = 8'd6; memB[2] = 8'd7; memB[3] = 8'd8;
  endtask

  task automatic check2x2(input string tag);
    checkOutput({tag, "_c0"}, memC[0], 32'd19);
    checkOutput({tag, "_c1"}, memC[1], 32'd22);
    checkOutput({tag, "_c2"}, memC[2], 32'd43);
    checkOutput({tag, "_c3"}, memC[3], 32'd50);
    checkOutput({tag, "_we_count"}, 32'(weCount), 32'd4);
    checkOutput({tag, "_done_cycle"}, 32'(doneCycle), 32'd17);
    checkOutput({tag, "_done_pulses"}, 32'(doneCount), 32'd1);
    checkOutput({tag, "_order"}, 32'(orderErr), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mSize = '0;
    kSize = '0;
    nSize = '0;
    for (int i = 0; i < 4096; i++) begin
      memA[i] = '0;
      memB[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_we",    32'(bus.sram_c_we), 32'd0);
    checkOutput("reset_done",  32'(doneO), 32'd0);
    checkOutput("reset_aaddr", 32'(bus.sram_a_addr), 32'd0);
    checkOutput("reset_caddr", 32'(bus.sram_c_addr), 32'd0);
    checkOutput("reset_wdata", bus.sram_c_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    load2x2();
    applyStimulus(2, 2, 2);
    waitDone("mm2", 100);
    check2x2("mm2");

    memA[0] = 8'h80; memB[0] = 8'h80;
    applyStimulus(1, 1, 1);
    waitDone("neg_neg", 50);
    checkOutput("neg_neg_c0", memC[0], 32'd16384);
    checkOutput("neg_neg_done_cycle", 32'(doneCycle), 32'd4);

    memB[0] = 8'h7f;
    applyStimulus(1, 1, 1);
    waitDone("neg_pos", 50);
    checkOutput("neg_pos_c0", memC[0], 32'hFFFF_C080);

    for (int i = 0; i < 32; i++) begin
      memA[i] = 8'h80;
      memB[i] = 8'h80;
    end
    applyStimulus(1, 32, 1);
    waitDone("k32", 100);
    checkOutput("k32_c0", memC[0], 32'd524288);
    checkOutput("k32_done_cycle", 32'(doneCycle), 32'd35);

    for (int r = 0; r < 10; r++) begin
      int m, k, n;
      m = $urandom_range(1, 16);
      k = $urandom_range(1, 32);
      n = $urandom_range(1, 16);
      for (int i = 0; i < m*k; i++) memA[i] = 8'($urandom);
      for (int i = 0; i < k*n; i++) memB[i] = 8'($urandom);
      applyStimulus(m, k, n);
      waitDone($sformatf("rand%0d", r), m*n*(k+2) + 20);
      checkOutput($sformatf("rand%0d_errors", r), 32'(goldenErrors(m, k, n)), 32'd0);
      checkOutput($sformatf("rand%0d_we_count", r), 32'(weCount), 32'(m*n));
      checkOutput($sformatf("rand%0d_done_cycle", r), 32'(doneCycle), 32'(m*n*(k+2)+1));
      checkOutput($sformatf("rand%0d_order", r), 32'(orderErr), 32'd0);
    end

    // Size change and a second start mid-run must not disturb the latched run.
    load2x2();
    for (int i = 4; i < 16; i++) begin
      memA[i] = 8'd9;
      memB[i] = 8'd9;
    end
    applyStimulus(2, 2, 2);
    repeat (5) @(negedge clk);
    mSize = 8'd3; kSize = 8'd3; nSize = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("midchg", 100);
    check2x2("midchg");
    repeat (10) @(negedge clk);
    #1;
    checkOutput("midchg_no_rerun", 32'(weCount), 32'd4);

    applyStimulus(0, 3, 3);
    waitDone("zero", 20);
    checkOutput("zero_done_cycle", 32'(doneCycle), 32'd1);
    checkOutput("zero_we_count", 32'(weCount), 32'd0);

    for (int i = 0; i < 16; i++) begin
      memA[i] = 8'd3;
      memB[i] = 8'd2;
    end
    applyStimulus(4, 4, 4);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_mid_we",    32'(bus.sram_c_we), 32'd0);
    checkOutput("rst_mid_done",  32'(doneO), 32'd0);
    checkOutput("rst_mid_aaddr", 32'(bus.sram_a_addr), 32'd0);
    checkOutput("rst_mid_baddr", 32'(bus.sram_b_addr), 32'd0);
    checkOutput("rst_mid_caddr", 32'(bus.sram_c_addr), 32'd0);
    checkOutput("rst_mid_wdata", bus.sram_c_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    checkOutput("rst_mid_no_writes", 32'(weCount), 32'd0);
    checkOutput("rst_mid_no_done", 32'(doneCount), 32'd0);

    load2x2();
    applyStimulus(2, 2, 2);
    waitDone("post_rst", 100);
    check2x2("post_rst");

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
